// File: rtl/rom_8x8_if.sv
// Bundles the read port and the self-check scan port of the coefficient ROM.
// The bench drives the master side and the ROM sits on the slave side.
// The clock and reset are plain ports on the module, not part of this bundle.
interface rom_8x8_if;
  logic       rd_en;
  logic [2:0] addr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_parity;
  logic       scan_start;
  logic       scan_busy;
  logic       scan_done;
  logic [7:0] checksum;

  modport master (
    output rd_en, addr, scan_start,
    input  data_out, data_valid, data_parity, scan_busy, scan_done, checksum
  );

  modport slave (
    input  rd_en, addr, scan_start,
    output data_out, data_valid, data_parity, scan_busy, scan_done, checksum
  );
endinterface

// File: rtl/rom_8x8.sv
// Purpose: fixed 8x8 coefficient ROM with a registered read port, even parity and an XOR-fold self-check scan.
// Latency: reads take 1 cycle. A scan is busy for 8 cycles and pulses done with the checksum on the 9th cycle.
// Backpressure: none; reads requested while a scan runs are dropped, and a scan request wins over a read issued in the same cycle.
module rom_8x8 (
  input  logic      clk,
  input  logic      rst_n,
  rom_8x8_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] scan_addr_q, scan_addr_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] checksum_q, checksum_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_parity_q, data_parity_d;
  logic       data_valid_q, data_valid_d;
  logic       scan_busy_q, scan_busy_d;
  logic       scan_done_q, scan_done_d;
  logic       start_scan;
  logic       rd_accept;

  function automatic logic [7:0] rom_word(input logic [2:0] a);
    logic [7:0] w;
    case (a)
      3'd0:    w = 8'h0A;
      3'd1:    w = 8'h1B;
      3'd2:    w = 8'h2C;
      3'd3:    w = 8'h3D;
      3'd4:    w = 8'h4E;
      3'd5:    w = 8'h5F;
      3'd6:    w = 8'h60;
      default: w = 8'h7E;
    endcase
    return w;
  endfunction

  // A scan starts only from IDLE. Reads are refused while scanning and when a scan starts in the same cycle.
  assign start_scan = (state_q == IDLE) && bus.scan_start;
  assign rd_accept  = bus.rd_en && (state_q != SCAN) && !start_scan;

  // Next-state logic for the scan FSM, the read port and the registered status outputs.
  always_comb begin
    state_d       = state_q;
    scan_addr_d   = scan_addr_q;
    acc_d         = acc_q;
    checksum_d    = checksum_q;
    data_out_d    = data_out_q;
    data_parity_d = data_parity_q;
    data_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_scan) begin
          state_d     = SCAN;
          scan_addr_d = 3'd0;
          acc_d       = 8'h00;
        end
      end
      SCAN: begin
        acc_d       = acc_q ^ rom_word(scan_addr_q);
        scan_addr_d = scan_addr_q + 3'd1;
        if (scan_addr_q == 3'd7) begin
          state_d    = DONE;
          // Load the checksum on the last fold so it appears in the same cycle as scan_done.
          checksum_d = acc_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_accept) begin
      data_out_d    = rom_word(bus.addr);
      data_parity_d = ^data_out_d;
      data_valid_d  = 1'b1;
    end

    scan_busy_d = (state_d == SCAN);
    scan_done_d = (state_d == DONE);
  end

  // All state and outputs are registered. A reset aborts any scan in progress without issuing scan_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      scan_addr_q   <= 3'd0;
      acc_q         <= 8'h00;
      checksum_q    <= 8'h00;
      data_out_q    <= 8'h00;
      data_parity_q <= 1'b0;
      data_valid_q  <= 1'b0;
      scan_busy_q   <= 1'b0;
      scan_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_addr_q   <= scan_addr_d;
      acc_q         <= acc_d;
      checksum_q    <= checksum_d;
      data_out_q    <= data_out_d;
      data_parity_q <= data_parity_d;
      data_valid_q  <= data_valid_d;
      scan_busy_q   <= scan_busy_d;
      scan_done_q   <= scan_done_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_parity = data_parity_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.scan_busy   = scan_busy_q;
  assign bus.scan_done   = scan_done_q;
  assign bus.checksum    = checksum_q;

endmodule

// File: tb/tb_rom_8x8.sv
// Directed bench for rom_8x8: reset, read sweep, hold, scan, collision and abort.
// Inputs change 1 ns after each rising edge and outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_rom_8x8;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  rom_8x8_if bus_if ();

  rom_8x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data_out"},    bus_if.data_out,           8'h00);
    check({tag, ".data_parity"}, {7'd0, bus_if.data_parity}, 8'h00);
    check({tag, ".data_valid"},  {7'd0, bus_if.data_valid},  8'h00);
    check({tag, ".scan_busy"},   {7'd0, bus_if.scan_busy},   8'h00);
    check({tag, ".scan_done"},   {7'd0, bus_if.scan_done},   8'h00);
    check({tag, ".checksum"},    bus_if.checksum,           8'h00);
  endtask

  logic [7:0] exp_data [8];
  logic       exp_par  [8];

  initial begin
    errors = 0;
    checks = 0;
    exp_data = '{8'h0A, 8'h1B, 8'h2C, 8'h3D, 8'h4E, 8'h5F, 8'h60, 8'h7E};
    exp_par  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    bus_if.rd_en      = 1'b0;
    bus_if.addr       = 3'd0;
    bus_if.scan_start = 1'b0;
    rst_n             = 1'b0;

    // Power-on reset state
    #2;
    check_all_zero("por");
    #10;
    rst_n = 1'b1;

    // Read address 7, then assert reset mid-cycle: outputs clear with no clock edge
    bus_if.rd_en = 1'b1;
    bus_if.addr  = 3'd7;
    tick();
    check("pre_rst.data_out", bus_if.data_out, 8'h7E);
    bus_if.rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2;
    rst_n = 1'b1;

    // Back-to-back sweep of all addresses
    for (int i = 0; i < 8; i++) begin
      bus_if.rd_en = 1'b1;
      bus_if.addr  = 3'(i);
      tick();
      check($sformatf("sweep%0d.data", i),   bus_if.data_out,            exp_data[i]);
      check($sformatf("sweep%0d.parity", i), {7'd0, bus_if.data_parity}, {7'd0, exp_par[i]});
      check($sformatf("sweep%0d.valid", i),  {7'd0, bus_if.data_valid},  8'h01);
    end

    // Hold: read address 3, then drop rd_en
    bus_if.addr = 3'd3;
    tick();
    check("hold.rd", bus_if.data_out, 8'h3D);
    bus_if.rd_en = 1'b0;
    tick();
    check("hold.data",   bus_if.data_out,           8'h3D);
    check("hold.parity", {7'd0, bus_if.data_parity}, 8'h01);
    check("hold.valid",  {7'd0, bus_if.data_valid},  8'h00);

    // Scan started together with a read: the scan wins and the read is dropped
    bus_if.scan_start = 1'b1;
    bus_if.rd_en      = 1'b1;
    bus_if.addr       = 3'd0;
    tick();
    bus_if.scan_start = 1'b0;
    bus_if.rd_en      = 1'b0;
    check("scan0.busy",  {7'd0, bus_if.scan_busy},  8'h01);
    check("scan0.valid", {7'd0, bus_if.data_valid}, 8'h00);
    check("scan0.data",  bus_if.data_out,           8'h3D);

    // Remaining busy cycles, with a read and a repeated scan_start on the 2nd
    for (int k = 1; k < 8; k++) begin
      bus_if.rd_en      = (k == 2);
      bus_if.addr       = 3'd5;
      bus_if.scan_start = (k == 2);
      tick();
      bus_if.rd_en      = 1'b0;
      bus_if.scan_start = 1'b0;
      check($sformatf("scan%0d.busy", k),  {7'd0, bus_if.scan_busy},  8'h01);
      check($sformatf("scan%0d.done", k),  {7'd0, bus_if.scan_done},  8'h00);
      check($sformatf("scan%0d.valid", k), {7'd0, bus_if.data_valid}, 8'h00);
      check($sformatf("scan%0d.data", k),  bus_if.data_out,           8'h3D);
      check($sformatf("scan%0d.csum", k),  bus_if.checksum,           8'h00);
    end

    // DONE cycle
    tick();
    check("done.busy", {7'd0, bus_if.scan_busy}, 8'h00);
    check("done.done", {7'd0, bus_if.scan_done}, 8'h01);
    check("done.csum", bus_if.checksum,          8'h0F);

    // Back in IDLE: checksum held, done gone, and a read works again
    bus_if.rd_en = 1'b1;
    bus_if.addr  = 3'd1;
    tick();
    bus_if.rd_en = 1'b0;
    check("post.done",  {7'd0, bus_if.scan_done},  8'h00);
    check("post.busy",  {7'd0, bus_if.scan_busy},  8'h00);
    check("post.csum",  bus_if.checksum,           8'h0F);
    check("post.data",  bus_if.data_out,           8'h1B);
    check("post.valid", {7'd0, bus_if.data_valid}, 8'h01);

    // Abort: reset in the 4th scan cycle
    bus_if.scan_start = 1'b1;
    tick();
    bus_if.scan_start = 1'b0;
    tick();
    tick();
    tick();
    check("abort.pre_busy", {7'd0, bus_if.scan_busy}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.busy", {7'd0, bus_if.scan_busy}, 8'h00);
    check("abort.csum", bus_if.checksum,          8'h00);
    check("abort.done", {7'd0, bus_if.scan_done}, 8'h00);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("abort_after%0d.done", k), {7'd0, bus_if.scan_done}, 8'h00);
      check($sformatf("abort_after%0d.busy", k), {7'd0, bus_if.scan_busy}, 8'h00);
    end
    check("abort_after.csum", bus_if.checksum, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom_8x8.md
# rom_8x8

Synchronous 8-entry by 8-bit read-only lookup table with a registered read port, even-parity flag and a built-in content self-check scan. It is the constant-coefficient store for downstream datapath blocks. Software and test logic can trigger a full scan that XOR-folds all entries into a checksum to confirm the table contents.

## Interface
- Parameters: none. Depth is 8 and width is 8, both fixed.
- clk  input  1  rising-edge clock; the design has one clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rd_en  input  1  read request; samples `addr` on the clock edge.
- addr  input  3  read address, 0..7.
- data_out  output  8  registered read data.
- data_valid  output  1  high for one cycle when `data_out` holds the data for the previous cycle's request.
- data_parity  output  1  even-parity bit, equal to the XOR of all `data_out` bits; registered together with `data_out`.
- scan_start  input  1  one-cycle pulse that starts a content self-check.
- scan_busy  output  1  high while a scan is running.
- scan_done  output  1  one-cycle pulse when a scan completes.
- checksum  output  8  XOR of all 8 entries; updated at scan end and held until the next scan ends.

## Operation
- Contents are fixed in RTL:
  - 0: 0x0A
  - 1: 0x1B
  - 2: 0x2C
  - 3: 0x3D
  - 4: 0x4E
  - 5: 0x5F
  - 6: 0x60
  - 7: 0x7E
- Normal read, with `rd_en` = 1 and no scan running:
  - the next edge loads `data_out` with `ROM[addr]` and `data_parity` with `^ROM[addr]`;
  - `data_valid` is set to 1.
- `rd_en` = 0: `data_out` and `data_parity` hold; `data_valid` = 0.
- Scan state machine has states IDLE, SCAN and DONE.
  - IDLE → SCAN on `scan_start` = 1. The internal scan address resets to 0 and the accumulator clears to 0.
  - In SCAN, each cycle XORs `ROM[scan_addr]` into the accumulator and increments `scan_addr`. After address 7 it moves to DONE.
  - In DONE, `checksum` is loaded from the accumulator and `scan_done` = 1 for that one cycle; the FSM then returns to IDLE.
- `scan_start` in SCAN or DONE is ignored.
- While `scan_busy` = 1, `rd_en` is ignored: `data_valid` = 0 and `data_out` holds.
- `rd_en` and `scan_start` asserted in the same cycle from IDLE: the scan wins and the read is dropped.
- The scan address wraps naturally at 3 bits; no out-of-range address exists.

## Timing
- Read latency is 1 cycle: request at edge N, data and `data_valid` visible after edge N.
- Back-to-back reads are fully pipelined, one per cycle.
- Scan timing:
  - `scan_busy` rises after the edge that samples `scan_start` and stays high for 8 cycles;
  - `scan_done` and the new `checksum` appear on the 9th cycle;
  - `scan_busy` is 0 in the DONE cycle;
  - a new read or scan is accepted in the DONE cycle's next edge.
- Reset value of every output is 0: `data_out` = 0x00, `data_parity` = 0, `data_valid` = 0, `scan_busy` = 0, `scan_done` = 0, `checksum` = 0x00.
- Reset mid-scan aborts immediately: FSM goes to IDLE, accumulator clears, and no `scan_done` is issued.
- Expected `checksum` for the fixed contents is 0x0F.

## Test plan
- Reset: assert `rst_n` = 0 asynchronously mid-cycle → all outputs 0 at once without waiting for a clock edge.
- Sweep: `rd_en` = 1 with `addr` 0..7 on consecutive cycles, 10 ns apart → `data_out` reads 0x0A, 0x1B, 0x2C, 0x3D, 0x4E, 0x5F, 0x60, 0x7E one cycle later each; `data_parity` reads 0, 0, 1, 1, 0, 0, 0, 0; `data_valid` is high throughout.
- Hold: read `addr` 3, then drop `rd_en` → `data_out` stays 0x3D and `data_valid` = 0.
- Scan: pulse `scan_start` → `scan_busy` high for 8 cycles, then `scan_done` pulses with `checksum` = 0x0F.
- Collision: during the scan, `rd_en` = 1 with `addr` 5 → `data_valid` stays 0 and `data_out` is unchanged; a repeated `scan_start` is ignored.
- Abort: reset on the 4th scan cycle → `scan_busy` = 0 at once, `checksum` = 0x00, and no `scan_done`.
